// File: rtl/icache_param.sv
// icache_param: read-only instruction cache with configurable sets, 1/2-way LRU,
// multi-word block fills, whole-cache invalidate and saturating hit/miss counters.
module icache_param #(
   parameter int unsigned SETS        = 8,
   parameter int unsigned WAYS        = 1,
   parameter int unsigned BLOCK_WORDS = 2,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   input  logic             invalidate,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int unsigned WO_W    = $clog2(BLOCK_WORDS);
   localparam int unsigned WC_W    = (WO_W == 0) ? 1 : WO_W;
   localparam int unsigned IDX_W   = $clog2(SETS);
   localparam int unsigned TAG_W   = 32 - 2 - WO_W - IDX_W;
   localparam int unsigned IDX_LSB = 2 + WO_W;
   localparam int unsigned TAG_LSB = 2 + WO_W + IDX_W;

   typedef enum logic [0:0] {IDLE, FILL} state_e;

   // Line storage; only the valid and LRU bits need reset.
   logic [31:0]      data_q  [WAYS][SETS][BLOCK_WORDS];
   logic [TAG_W-1:0] tag_q   [WAYS][SETS];
   logic [SETS-1:0]  valid_q [WAYS];
   logic [SETS-1:0]  valid_d [WAYS];
   logic [SETS-1:0]  lru_q, lru_d;

   state_e           state_q, state_d;
   logic [WC_W-1:0]  wc_q, wc_d;
   logic [TAG_W-1:0] ftag_q, ftag_d;
   logic [IDX_W-1:0] fidx_q, fidx_d;
   logic             fway_q, fway_d;
   logic             inv_q, inv_d;
   logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
   logic             word_we, line_we;

   logic [WC_W-1:0]  req_wo;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [WAYS-1:0]  way_hit;
   logic             match;
   logic             hit_way;
   logic [31:0]      hit_word;
   logic             victim;
   logic             inv_pend;
   logic             last_word;

   assign req_wo    = WC_W'((imemaddr >> 2) & 32'(BLOCK_WORDS - 1));
   assign req_idx   = IDX_W'(imemaddr >> IDX_LSB);
   assign req_tag   = TAG_W'(imemaddr >> TAG_LSB);
   assign inv_pend  = inv_q | invalidate;
   assign last_word = (wc_q == WC_W'(BLOCK_WORDS - 1));
   assign match     = |way_hit;

   // Tag compare across ways and selection of the matching word.
   always_comb begin
      way_hit  = '0;
      hit_way  = 1'b0;
      hit_word = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         way_hit[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
         if (way_hit[w]) begin
            hit_way  = 1'(w);
            hit_word = data_q[w][req_idx][req_wo];
         end
      end
   end

   // Victim: lowest-numbered invalid way, otherwise the LRU way.
   always_comb begin
      victim = (WAYS == 2) ? lru_q[req_idx] : 1'b0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[w][req_idx]) victim = 1'(w);
      end
   end

   // Next-state, control strobes and fetch/memory-side outputs.
   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      ftag_d  = ftag_q;
      fidx_d  = fidx_q;
      fway_d  = fway_q;
      inv_d   = inv_pend;
      valid_d = valid_q;
      lru_d   = lru_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      word_we = 1'b0;
      line_we = 1'b0;
      ihit    = 1'b0;
      iREN    = 1'b0;
      iaddr   = '0;
      unique case (state_q)
         IDLE: begin
            if (inv_pend) begin
               for (int w = 0; w < int'(WAYS); w++) valid_d[w] = '0;
               lru_d = '0;
               inv_d = 1'b0;
            end else if (imemREN) begin
               if (match) begin
                  ihit = 1'b1;
                  if (WAYS == 2) lru_d[req_idx] = ~hit_way;
                  if (~&hit_q) hit_d = hit_q + CNT_W'(1);
               end else begin
                  state_d = FILL;
                  wc_d    = '0;
                  ftag_d  = req_tag;
                  fidx_d  = req_idx;
                  fway_d  = victim;
                  if (~&miss_q) miss_d = miss_q + CNT_W'(1);
               end
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = (32'(ftag_q) << TAG_LSB) | (32'(fidx_q) << IDX_LSB) | (32'(wc_q) << 2);
            if (!iwait) begin
               word_we = 1'b1;
               wc_d    = wc_q + WC_W'(1);
               if (last_word) begin
                  line_we = 1'b1;
                  state_d = IDLE;
                  wc_d    = '0;
                  for (int w = 0; w < int'(WAYS); w++) begin
                     if (1'(w) == fway_q) valid_d[w][fidx_q] = 1'b1;
                  end
                  if (WAYS == 2) lru_d[fidx_q] = ~fway_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imemload   = ihit ? hit_word : 32'd0;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         wc_q    <= '0;
         ftag_q  <= '0;
         fidx_q  <= '0;
         fway_q  <= 1'b0;
         inv_q   <= 1'b0;
         lru_q   <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
         for (int w = 0; w < int'(WAYS); w++) valid_q[w] <= '0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         ftag_q  <= ftag_d;
         fidx_q  <= fidx_d;
         fway_q  <= fway_d;
         inv_q   <= inv_d;
         lru_q   <= lru_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         for (int w = 0; w < int'(WAYS); w++) valid_q[w] <= valid_d[w];
      end
   end

   always_ff @(posedge CLK) begin
      for (int w = 0; w < int'(WAYS); w++) begin
         if (word_we && (1'(w) == fway_q)) data_q[w][fidx_q][wc_q] <= iload;
         if (line_we && (1'(w) == fway_q)) tag_q[w][fidx_q]        <= ftag_q;
      end
   end
endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: directed and randomized checks of icache_param against a
// line-level cache model; instance 0 is direct-mapped, instance 1 is 2-way.
module tb_icache_param;
   localparam int unsigned SETS = 8;
   localparam int unsigned BW   = 2;
   localparam int unsigned CW   = 4;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          nrst;
   logic          ren   [2];
   logic [31:0]   addr  [2];
   logic          inv   [2];
   logic          iwait [2];
   logic          ihit  [2];
   logic [31:0]   load  [2];
   logic          iren  [2];
   logic [31:0]   iaddr [2];
   logic [31:0]   iload [2];
   logic [CW-1:0] hc    [2];
   logic [CW-1:0] mc    [2];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   icache_param #(.SETS(SETS), .WAYS(1), .BLOCK_WORDS(BW), .CNT_W(CW)) u_dm (
      .CLK(clk), .nRST(nrst), .imemREN(ren[0]), .imemaddr(addr[0]), .ihit(ihit[0]),
      .imemload(load[0]), .invalidate(inv[0]), .iREN(iren[0]), .iaddr(iaddr[0]),
      .iwait(iwait[0]), .iload(iload[0]), .hit_count(hc[0]), .miss_count(mc[0]));

   icache_param #(.SETS(SETS), .WAYS(2), .BLOCK_WORDS(BW), .CNT_W(CW)) u_2w (
      .CLK(clk), .nRST(nrst), .imemREN(ren[1]), .imemaddr(addr[1]), .ihit(ihit[1]),
      .imemload(load[1]), .invalidate(inv[1]), .iREN(iren[1]), .iaddr(iaddr[1]),
      .iwait(iwait[1]), .iload(iload[1]), .hit_count(hc[1]), .miss_count(mc[1]));

   // Backing memory: every word address holds a distinct value.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return 32'hAAAA_0000 + (a >> 2) - 32'd3;
   endfunction

   always_comb begin
      iload[0] = mem_val(iaddr[0]);
      iload[1] = mem_val(iaddr[1]);
   end

   // Reference model: lines held as block numbers; data comes from mem_val.
   bit          m_valid [2][2][SETS];
   logic [31:0] m_blk   [2][2][SETS];
   int          m_lru   [2][SETS];
   bit          m_busy  [2];
   logic [31:0] m_fblk  [2];
   int          m_fway  [2];
   int          m_wc    [2];
   bit          m_inv   [2];
   int          m_hits  [2];
   int          m_miss  [2];
   bit          e_ihit  [2];
   logic [31:0] e_load  [2];
   bit          e_iren  [2];
   logic [31:0] e_iaddr [2];

   function automatic int find_way(input int d, input logic [31:0] a);
      int s = int'((a >> 3) % SETS);
      for (int w = 0; w <= d; w++)
         if (m_valid[d][w][s] && m_blk[d][w][s] == (a >> 3)) return w;
      return -1;
   endfunction

   task automatic predict(input int d);
      e_ihit[d] = 0; e_load[d] = '0; e_iren[d] = 0; e_iaddr[d] = '0;
      if (m_busy[d]) begin
         e_iren[d]  = 1;
         e_iaddr[d] = (m_fblk[d] << 3) + 32'(m_wc[d] * 4);
      end else if (ren[d] && !m_inv[d] && !inv[d] && find_way(d, addr[d]) >= 0) begin
         e_ihit[d] = 1;
         e_load[d] = mem_val(addr[d]);
      end
   endtask

   task automatic model_clock(input int d);
      int  s;
      int  w;
      bit  pend;
      pend = m_inv[d] || inv[d];
      if (!nrst) begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < int'(SETS); j++) m_valid[d][i][j] = 0;
         for (int j = 0; j < int'(SETS); j++) m_lru[d][j] = 0;
         m_busy[d] = 0; m_inv[d] = 0; m_wc[d] = 0; m_hits[d] = 0; m_miss[d] = 0;
      end else if (!m_busy[d]) begin
         if (pend) begin
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < int'(SETS); j++) m_valid[d][i][j] = 0;
            for (int j = 0; j < int'(SETS); j++) m_lru[d][j] = 0;
            m_inv[d] = 0;
         end else if (ren[d]) begin
            s = int'((addr[d] >> 3) % SETS);
            w = find_way(d, addr[d]);
            if (w >= 0) begin
               if (m_hits[d] < CMAX) m_hits[d]++;
               m_lru[d][s] = 1 - w;
            end else begin
               if (m_miss[d] < CMAX) m_miss[d]++;
               m_busy[d] = 1; m_fblk[d] = addr[d] >> 3; m_wc[d] = 0; m_fway[d] = -1;
               for (int i = d; i >= 0; i--) if (!m_valid[d][i][s]) m_fway[d] = i;
               if (m_fway[d] < 0) m_fway[d] = (d == 1) ? m_lru[d][s] : 0;
            end
         end
      end else begin
         m_inv[d] = pend;
         if (!iwait[d]) begin
            m_wc[d]++;
            if (m_wc[d] == int'(BW)) begin
               s = int'(m_fblk[d] % SETS);
               m_valid[d][m_fway[d]][s] = 1;
               m_blk[d][m_fway[d]][s]   = m_fblk[d];
               m_lru[d][s] = 1 - m_fway[d];
               m_busy[d] = 0;
            end
         end
      end
   endtask

   // Called at the falling edge with inputs stable; ends 1 time unit after the rising edge.
   task automatic advance();
      model_clock(0);
      model_clock(1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         ren[d] = 1'b0; addr[d] = '0; inv[d] = 1'b0; iwait[d] = 1'b0;
      end
      @(negedge clk); advance();
      @(negedge clk); advance();
      nrst = 1'b1;
   endtask

   task automatic fetch(input int d, input logic [31:0] a, output int lat, output logic [31:0] data);
      lat = -1; data = 'x;
      ren[d] = 1'b1; addr[d] = a;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ihit[d] === 1'b1) begin
            lat = n; data = load[d];
            advance();
            break;
         end
         advance();
      end
      ren[d] = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         ren[d] = 1'b1; addr[d] = 32'h10; inv[d] = 1'b0; iwait[d] = 1'b0;
      end
      @(negedge clk); advance();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks += 6;
         if (ihit[d] !== 1'b0) begin errors++; $display("FAIL reset_ihit[%0d] got %b want 0", d, ihit[d]); end
         if (load[d] !== 32'd0) begin errors++; $display("FAIL reset_load[%0d] got %h want 0", d, load[d]); end
         if (iren[d] !== 1'b0) begin errors++; $display("FAIL reset_iren[%0d] got %b want 0", d, iren[d]); end
         if (iaddr[d] !== 32'd0) begin errors++; $display("FAIL reset_iaddr[%0d] got %h want 0", d, iaddr[d]); end
         if (hc[d] !== '0) begin errors++; $display("FAIL reset_hits[%0d] got %0d want 0", d, hc[d]); end
         if (mc[d] !== '0) begin errors++; $display("FAIL reset_miss[%0d] got %0d want 0", d, mc[d]); end
      end
      advance();
      nrst = 1'b1; ren[0] = 1'b0; ren[1] = 1'b0;
   endtask

   task automatic test_cold_miss();
      logic [31:0] exp_a [2] = '{32'h10, 32'h14};
      do_reset();
      ren[0] = 1'b1; addr[0] = 32'h10;
      @(negedge clk);
      checks += 2;
      if (ihit[0] !== 1'b0) begin errors++; $display("FAIL cold_detect_ihit got %b want 0", ihit[0]); end
      if (iren[0] !== 1'b0) begin errors++; $display("FAIL cold_detect_iren got %b want 0", iren[0]); end
      advance();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks += 2;
         if (iren[0] !== 1'b1) begin errors++; $display("FAIL cold_iren w%0d got %b want 1", k, iren[0]); end
         if (iaddr[0] !== exp_a[k]) begin errors++; $display("FAIL cold_iaddr w%0d got %h want %h", k, iaddr[0], exp_a[k]); end
         advance();
      end
      @(negedge clk);
      checks += 3;
      if (ihit[0] !== 1'b1) begin errors++; $display("FAIL cold_ihit got %b want 1", ihit[0]); end
      if (load[0] !== 32'hAAAA_0001) begin errors++; $display("FAIL cold_load got %h want AAAA0001", load[0]); end
      if (iren[0] !== 1'b0) begin errors++; $display("FAIL cold_iren_idle got %b want 0", iren[0]); end
      advance();
      addr[0] = 32'h14;
      @(negedge clk);
      checks += 3;
      if (ihit[0] !== 1'b1) begin errors++; $display("FAIL cold_word1_ihit got %b want 1", ihit[0]); end
      if (load[0] !== 32'hAAAA_0002) begin errors++; $display("FAIL cold_word1_load got %h want AAAA0002", load[0]); end
      if (mc[0] !== CW'(1)) begin errors++; $display("FAIL cold_miss_count got %0d want 1", mc[0]); end
      advance();
      ren[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (hc[0] !== CW'(2)) begin errors++; $display("FAIL cold_hit_count got %0d want 2", hc[0]); end
      advance();
   endtask

   task automatic test_conflict_lru();
      logic [31:0] seq [6] = '{32'h00, 32'h40, 32'h00, 32'h80, 32'h00, 32'h40};
      int lat_dm [3] = '{3, 3, 3};
      int lat_2w [6] = '{3, 3, 0, 3, 0, 3};
      int lat;
      logic [31:0] data;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         fetch(0, seq[i], lat, data);
         checks += 2;
         if (lat !== lat_dm[i]) begin errors++; $display("FAIL conflict_dm_lat[%0d] got %0d want %0d", i, lat, lat_dm[i]); end
         if (data !== mem_val(seq[i])) begin errors++; $display("FAIL conflict_dm_data[%0d] got %h want %h", i, data, mem_val(seq[i])); end
      end
      for (int i = 0; i < 6; i++) begin
         fetch(1, seq[i], lat, data);
         checks += 2;
         if (lat !== lat_2w[i]) begin errors++; $display("FAIL conflict_2w_lat[%0d] got %0d want %0d", i, lat, lat_2w[i]); end
         if (data !== mem_val(seq[i])) begin errors++; $display("FAIL conflict_2w_data[%0d] got %h want %h", i, data, mem_val(seq[i])); end
      end
      @(negedge clk);
      checks += 2;
      if (mc[0] !== CW'(3)) begin errors++; $display("FAIL conflict_dm_miss got %0d want 3", mc[0]); end
      if (mc[1] !== CW'(4)) begin errors++; $display("FAIL conflict_2w_miss got %0d want 4", mc[1]); end
      advance();
   endtask

   task automatic test_iwait_stretch();
      logic [31:0] exp_a;
      do_reset();
      ren[0] = 1'b1; addr[0] = 32'h20;
      @(negedge clk); advance();
      for (int k = 1; k <= 8; k++) begin
         iwait[0] = (k % 4 != 0);
         if (k == 3) ren[0] = 1'b0;
         exp_a = (k <= 4) ? 32'h20 : 32'h24;
         @(negedge clk);
         checks += 3;
         if (iren[0] !== 1'b1) begin errors++; $display("FAIL stall_iren c%0d got %b want 1", k, iren[0]); end
         if (iaddr[0] !== exp_a) begin errors++; $display("FAIL stall_iaddr c%0d got %h want %h", k, iaddr[0], exp_a); end
         if (ihit[0] !== 1'b0) begin errors++; $display("FAIL stall_ihit c%0d got %b want 0", k, ihit[0]); end
         advance();
      end
      iwait[0] = 1'b0; ren[0] = 1'b1;
      @(negedge clk);
      checks += 3;
      if (ihit[0] !== 1'b1) begin errors++; $display("FAIL stall_ihit_c9 got %b want 1", ihit[0]); end
      if (load[0] !== 32'hAAAA_0005) begin errors++; $display("FAIL stall_load got %h want AAAA0005", load[0]); end
      if (mc[0] !== CW'(1)) begin errors++; $display("FAIL stall_miss got %0d want 1", mc[0]); end
      advance();
      ren[0] = 1'b0;
   endtask

   task automatic test_invalidate();
      int lat;
      logic [31:0] data;
      do_reset();
      ren[0] = 1'b1; addr[0] = 32'h30;
      @(negedge clk); advance();
      inv[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (iren[0] !== 1'b1) begin errors++; $display("FAIL inv_fill_iren got %b want 1", iren[0]); end
      advance();
      inv[0] = 1'b0;
      @(negedge clk); advance();
      @(negedge clk);
      checks += 2;
      if (ihit[0] !== 1'b0) begin errors++; $display("FAIL inv_after_fill_ihit got %b want 0", ihit[0]); end
      if (iren[0] !== 1'b0) begin errors++; $display("FAIL inv_after_fill_iren got %b want 0", iren[0]); end
      advance();
      fetch(0, 32'h30, lat, data);
      @(negedge clk);
      checks += 2;
      if (lat !== 3) begin errors++; $display("FAIL inv_refetch_lat got %0d want 3", lat); end
      if (mc[0] !== CW'(2)) begin errors++; $display("FAIL inv_refetch_miss got %0d want 2", mc[0]); end
      advance();
      ren[0] = 1'b1; addr[0] = 32'h30; inv[0] = 1'b1;
      @(negedge clk);
      checks += 3;
      if (ihit[0] !== 1'b0) begin errors++; $display("FAIL inv_same_cycle_ihit got %b want 0", ihit[0]); end
      if (load[0] !== 32'd0) begin errors++; $display("FAIL inv_same_cycle_load got %h want 0", load[0]); end
      if (iren[0] !== 1'b0) begin errors++; $display("FAIL inv_same_cycle_iren got %b want 0", iren[0]); end
      advance();
      inv[0] = 1'b0;
      fetch(0, 32'h30, lat, data);
      @(negedge clk);
      checks += 3;
      if (lat !== 3) begin errors++; $display("FAIL inv_same_refetch_lat got %0d want 3", lat); end
      if (data !== 32'hAAAA_0009) begin errors++; $display("FAIL inv_same_refetch_data got %h want AAAA0009", data); end
      if (mc[0] !== CW'(3)) begin errors++; $display("FAIL inv_same_refetch_miss got %0d want 3", mc[0]); end
      advance();
   endtask

   task automatic test_reset_mid_fill();
      int lat;
      logic [31:0] data;
      do_reset();
      ren[0] = 1'b1; addr[0] = 32'h50;
      @(negedge clk); advance();
      @(negedge clk); advance();
      nrst = 1'b0;
      @(negedge clk);
      checks++;
      if (iaddr[0] !== 32'h54) begin errors++; $display("FAIL rstfill_iaddr got %h want 54", iaddr[0]); end
      advance();
      nrst = 1'b1; ren[0] = 1'b0;
      @(negedge clk);
      checks += 6;
      if (ihit[0] !== 1'b0) begin errors++; $display("FAIL rstfill_ihit got %b want 0", ihit[0]); end
      if (load[0] !== 32'd0) begin errors++; $display("FAIL rstfill_load got %h want 0", load[0]); end
      if (iren[0] !== 1'b0) begin errors++; $display("FAIL rstfill_iren got %b want 0", iren[0]); end
      if (iaddr[0] !== 32'd0) begin errors++; $display("FAIL rstfill_iaddr0 got %h want 0", iaddr[0]); end
      if (hc[0] !== '0) begin errors++; $display("FAIL rstfill_hits got %0d want 0", hc[0]); end
      if (mc[0] !== '0) begin errors++; $display("FAIL rstfill_miss got %0d want 0", mc[0]); end
      advance();
      fetch(0, 32'h50, lat, data);
      checks += 2;
      if (lat !== 3) begin errors++; $display("FAIL rstfill_refetch_lat got %0d want 3", lat); end
      if (data !== 32'hAAAA_0011) begin errors++; $display("FAIL rstfill_refetch_data got %h want AAAA0011", data); end
   endtask

   task automatic test_saturation();
      int lat;
      int want;
      logic [31:0] data;
      do_reset();
      fetch(0, 32'h60, lat, data);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL sat_fill_lat got %0d want 3", lat); end
      ren[0] = 1'b1; addr[0] = 32'h60;
      for (int i = 0; i < 20; i++) begin
         want = (1 + i > CMAX) ? CMAX : 1 + i;
         @(negedge clk);
         checks += 2;
         if (ihit[0] !== 1'b1) begin errors++; $display("FAIL sat_ihit[%0d] got %b want 1", i, ihit[0]); end
         if (hc[0] !== CW'(want)) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, hc[0], want); end
         advance();
      end
      ren[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (hc[0] !== CW'(CMAX)) begin errors++; $display("FAIL sat_final got %0d want %0d", hc[0], CMAX); end
      advance();
   endtask

   task automatic test_random();
      logic [31:0] tags [4] = '{32'h0, 32'h1, 32'h2, 32'h3FF_FFFF};
      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         nrst = ($urandom_range(0, 199) != 0);
         for (int d = 0; d < 2; d++) begin
            ren[d]   = ($urandom_range(0, 3) != 0);
            addr[d]  = (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 3)) << 3)
                       | (32'($urandom_range(0, 1)) << 2);
            inv[d]   = ($urandom_range(0, 49) == 0);
            iwait[d] = ($urandom_range(0, 3) == 0);
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            predict(d);
            checks += 6;
            if (ihit[d] !== e_ihit[d]) begin errors++; $display("FAIL rnd_ihit[%0d] c%0d got %b want %b", d, cyc, ihit[d], e_ihit[d]); end
            if (load[d] !== e_load[d]) begin errors++; $display("FAIL rnd_load[%0d] c%0d got %h want %h", d, cyc, load[d], e_load[d]); end
            if (iren[d] !== e_iren[d]) begin errors++; $display("FAIL rnd_iren[%0d] c%0d got %b want %b", d, cyc, iren[d], e_iren[d]); end
            if (iaddr[d] !== e_iaddr[d]) begin errors++; $display("FAIL rnd_iaddr[%0d] c%0d got %h want %h", d, cyc, iaddr[d], e_iaddr[d]); end
            if (hc[d] !== CW'(m_hits[d])) begin errors++; $display("FAIL rnd_hits[%0d] c%0d got %0d want %0d", d, cyc, hc[d], m_hits[d]); end
            if (mc[d] !== CW'(m_miss[d])) begin errors++; $display("FAIL rnd_miss[%0d] c%0d got %0d want %0d", d, cyc, mc[d], m_miss[d]); end
         end
         advance();
      end
      nrst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         ren[d] = 1'b0; inv[d] = 1'b0; iwait[d] = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_conflict_lru();
      test_iwait_stretch();
      test_invalidate();
      test_reset_mid_fill();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
